phv_action_aligner: RTL and testbench

//  Pairs each PHV with its action word for the crossbar/ALU stage and schedules issue under back-pressure.

---
 rtl/phv_action_aligner.sv | 156 +++++++++++++++
 tb/tb_phv_action_aligner.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phv_action_aligner.sv
// phv_action_aligner: buffers early PHVs in an in-order FIFO, pairs each with
// its lookup action word, and issues the pair on one valid/ready output.
module phv_action_aligner #(
  parameter int unsigned STAGE_ID = 0,
  parameter int unsigned PHV_LEN  = 1124,
  parameter int unsigned ACT_LEN  = 625,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PHV_LEN-1:0]       phv_in,
  input  logic                     phv_in_valid,
  output logic                     phv_in_ready,
  input  logic [ACT_LEN-1:0]       action_in,
  input  logic                     action_in_valid,
  output logic                     action_in_ready,
  output logic [PHV_LEN-1:0]       phv_out,
  output logic [ACT_LEN-1:0]       action_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]         pair_cnt,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic                     err_orphan
);

  localparam int unsigned PTR_W        = $clog2(DEPTH);
  localparam int unsigned LVL_W        = PTR_W + 1;
  localparam int unsigned ORPHAN_LIMIT = DEPTH * 4;
  localparam int unsigned TMR_W        = $clog2(ORPHAN_LIMIT) + 1;

  typedef enum logic {IDLE, SEND} state_e;

  logic [PHV_LEN-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [ACT_LEN-1:0] act_buf_q, act_buf_d;
  logic               act_vld_q, act_vld_d;
  state_e             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [PHV_LEN-1:0] phv_out_q, phv_out_d;
  logic [ACT_LEN-1:0] action_out_q, action_out_d;
  logic [CNT_W-1:0]   pair_cnt_q, pair_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               err_q, err_d;

  logic phv_fire, act_fire, pair_fire, orphan_cond;

  // Handshake qualifiers; PHV ready uses only the registered level.
  always_comb begin
    phv_in_ready    = (level_q < LVL_W'(DEPTH));
    pair_fire       = (level_q != '0) && act_vld_q && ((state_q == IDLE) || out_ready);
    action_in_ready = !act_vld_q || pair_fire;
    phv_fire        = phv_in_valid && phv_in_ready;
    act_fire        = action_in_valid && action_in_ready;
    orphan_cond     = act_vld_q && (level_q == '0);
  end

  // Next-state: FIFO pointers, action buffer, issue FSM, counters, orphan timer.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    act_buf_d    = act_buf_q;
    act_vld_d    = act_vld_q;
    state_d      = state_q;
    out_valid_d  = out_valid_q;
    phv_out_d    = phv_out_q;
    action_out_d = action_out_q;
    pair_cnt_d   = pair_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    tmr_d        = '0;
    err_d        = err_q;

    if (phv_fire)  wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pair_fire) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    level_d = level_q + LVL_W'(phv_fire) - LVL_W'(pair_fire);

    if (act_fire) begin
      act_buf_d = action_in;
      act_vld_d = 1'b1;
    end else if (pair_fire) begin
      act_vld_d = 1'b0;
    end

    if (pair_fire) begin
      phv_out_d    = mem_q[rd_ptr_q];
      action_out_d = act_buf_q;
      pair_cnt_d   = pair_cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: if (pair_fire) state_d = SEND;
      SEND: if (out_ready && !pair_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    out_valid_d = (state_d == SEND);

    if (out_valid_q && !out_ready) stall_cnt_d = stall_cnt_q + CNT_W'(1);

    if (orphan_cond) begin
      tmr_d = (tmr_q == TMR_W'(ORPHAN_LIMIT)) ? tmr_q : tmr_q + TMR_W'(1);
    end
    if (tmr_d == TMR_W'(ORPHAN_LIMIT)) err_d = 1'b1;
  end

  // FIFO storage; contents need no reset since pointers are cleared.
  always_ff @(posedge clk) begin
    if (phv_fire) mem_q[wr_ptr_q] <= phv_in;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      act_buf_q    <= '0;
      act_vld_q    <= 1'b0;
      state_q      <= IDLE;
      out_valid_q  <= 1'b0;
      phv_out_q    <= '0;
      action_out_q <= '0;
      pair_cnt_q   <= '0;
      stall_cnt_q  <= '0;
      tmr_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      act_buf_q    <= act_buf_d;
      act_vld_q    <= act_vld_d;
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      phv_out_q    <= phv_out_d;
      action_out_q <= action_out_d;
      pair_cnt_q   <= pair_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      tmr_q        <= tmr_d;
      err_q        <= err_d;
    end
  end

  assign phv_out    = phv_out_q;
  assign action_out = action_out_q;
  assign out_valid  = out_valid_q;
  assign fifo_level = level_q;
  assign pair_cnt   = pair_cnt_q;
  assign stall_cnt  = stall_cnt_q;
  assign err_orphan = err_q;

endmodule

// File: tb/tb_phv_action_aligner.sv
// Self-checking bench for phv_action_aligner: directed scenarios plus a
// randomized run scored against queue-based ordering model.
module tb_phv_action_aligner;

  localparam int unsigned PHV_LEN = 1124;
  localparam int unsigned ACT_LEN = 625;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned CNT_W   = 32;
  localparam int unsigned LVL_W   = 3;
  localparam int unsigned N_RAND  = 10000;
  localparam int unsigned CYC_LIM = 90000;

  logic               clk = 1'b0;
  logic               rst;
  logic [PHV_LEN-1:0] phv_in;
  logic               phv_in_valid;
  logic               phv_in_ready;
  logic [ACT_LEN-1:0] action_in;
  logic               action_in_valid;
  logic               action_in_ready;
  logic [PHV_LEN-1:0] phv_out;
  logic [ACT_LEN-1:0] action_out;
  logic               out_valid;
  logic               out_ready;
  logic [LVL_W-1:0]   fifo_level;
  logic [CNT_W-1:0]   pair_cnt;
  logic [CNT_W-1:0]   stall_cnt;
  logic               err_orphan;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  phv_action_aligner #(
    .STAGE_ID(0), .PHV_LEN(PHV_LEN), .ACT_LEN(ACT_LEN), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .phv_in(phv_in), .phv_in_valid(phv_in_valid), .phv_in_ready(phv_in_ready),
    .action_in(action_in), .action_in_valid(action_in_valid), .action_in_ready(action_in_ready),
    .phv_out(phv_out), .action_out(action_out), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_level(fifo_level), .pair_cnt(pair_cnt), .stall_cnt(stall_cnt), .err_orphan(err_orphan)
  );

  function automatic logic [PHV_LEN-1:0] rand_phv();
    logic [PHV_LEN-1:0] r;
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < int'(PHV_LEN); i++) begin
      if (i % 32 == 0) w = $urandom;
      r[i] = w[i % 32];
    end
    return r;
  endfunction

  function automatic logic [ACT_LEN-1:0] rand_act();
    logic [ACT_LEN-1:0] r;
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < int'(ACT_LEN); i++) begin
      if (i % 32 == 0) w = $urandom;
      r[i] = w[i % 32];
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    phv_in_valid    = 1'b0;
    action_in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    tests_run++;
    if (phv_out !== '0 || action_out !== '0) begin tests_failed++; $display("FAIL reset_data: got phv %0h act %0h expected 0", phv_out[63:0], action_out[63:0]); end
    tests_run++;
    if (fifo_level !== '0) begin tests_failed++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
    tests_run++;
    if (pair_cnt !== '0 || stall_cnt !== '0) begin tests_failed++; $display("FAIL reset_counters: got pair %0d stall %0d expected 0", pair_cnt, stall_cnt); end
    tests_run++;
    if (err_orphan !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %0b expected 0", err_orphan); end
    tests_run++;
    if (phv_in_ready !== 1'b1 || action_in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got phv %0b act %0b expected 1 1", phv_in_ready, action_in_ready); end
  endtask

  task automatic test_single_pair();
    logic [PHV_LEN-1:0] a;
    logic [ACT_LEN-1:0] x;
    do_reset();
    a = rand_phv();
    x = rand_act();
    out_ready = 1'b1;
    phv_in = a; phv_in_valid = 1'b1;
    action_in = x; action_in_valid = 1'b1;
    step();
    idle_inputs();
    tests_run++;
    if (out_valid !== 1'b0 || fifo_level !== LVL_W'(1)) begin tests_failed++; $display("FAIL single_latency: got valid %0b level %0d expected 0 1", out_valid, fifo_level); end
    step();
    tests_run++;
    if (out_valid !== 1'b1 || phv_out !== a || action_out !== x) begin tests_failed++; $display("FAIL single_pair: got valid %0b phv %0h act %0h expected 1 %0h %0h", out_valid, phv_out[63:0], action_out[63:0], a[63:0], x[63:0]); end
    tests_run++;
    if (pair_cnt !== CNT_W'(1) || fifo_level !== '0) begin tests_failed++; $display("FAIL single_cnt: got pair %0d level %0d expected 1 0", pair_cnt, fifo_level); end
    step();
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL single_idle: got %0b expected 0", out_valid); end
  endtask

  task automatic test_fill_then_drain();
    logic [PHV_LEN-1:0] a [4];
    logic [ACT_LEN-1:0] x [4];
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a[i] = rand_phv();
      x[i] = rand_act();
      phv_in = a[i]; phv_in_valid = 1'b1;
      step();
    end
    phv_in = rand_phv();
    tests_run++;
    if (fifo_level !== LVL_W'(4) || phv_in_ready !== 1'b0) begin tests_failed++; $display("FAIL fill_full: got level %0d ready %0b expected 4 0", fifo_level, phv_in_ready); end
    step();
    phv_in_valid = 1'b0;
    tests_run++;
    if (fifo_level !== LVL_W'(4) || out_valid !== 1'b0) begin tests_failed++; $display("FAIL fill_hold: got level %0d valid %0b expected 4 0", fifo_level, out_valid); end
    action_in = x[0]; action_in_valid = 1'b1;
    step();
    for (int k = 1; k <= 4; k++) begin
      if (k < 4) action_in = x[k];
      else action_in_valid = 1'b0;
      step();
      tests_run++;
      if (out_valid !== 1'b1 || phv_out !== a[k-1] || action_out !== x[k-1]) begin
        tests_failed++;
        $display("FAIL drain_pair%0d: got valid %0b phv %0h act %0h expected 1 %0h %0h", k-1, out_valid, phv_out[63:0], action_out[63:0], a[k-1][63:0], x[k-1][63:0]);
      end
    end
    step();
    tests_run++;
    if (out_valid !== 1'b0 || pair_cnt !== CNT_W'(4) || fifo_level !== '0 || phv_in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL drain_end: got valid %0b pair %0d level %0d ready %0b expected 0 4 0 1", out_valid, pair_cnt, fifo_level, phv_in_ready);
    end
  endtask

  task automatic test_stall();
    logic [PHV_LEN-1:0] a;
    logic [ACT_LEN-1:0] x;
    int unstable;
    do_reset();
    a = rand_phv();
    x = rand_act();
    phv_in = a; phv_in_valid = 1'b1;
    action_in = x; action_in_valid = 1'b1;
    step();
    idle_inputs();
    step();
    tests_run++;
    if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL stall_start: got %0b expected 1", out_valid); end
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_valid !== 1'b1 || phv_out !== a || action_out !== x) unstable++;
    end
    tests_run++;
    if (unstable != 0) begin tests_failed++; $display("FAIL stall_stable: got %0d unstable cycles expected 0", unstable); end
    tests_run++;
    if (stall_cnt !== CNT_W'(10)) begin tests_failed++; $display("FAIL stall_cnt: got %0d expected 10", stall_cnt); end
    out_ready = 1'b1;
    step();
    tests_run++;
    if (out_valid !== 1'b0 || stall_cnt !== CNT_W'(10) || pair_cnt !== CNT_W'(1)) begin
      tests_failed++;
      $display("FAIL stall_release: got valid %0b stall %0d pair %0d expected 0 10 1", out_valid, stall_cnt, pair_cnt);
    end
  endtask

  task automatic test_orphan();
    logic [PHV_LEN-1:0] b;
    logic [ACT_LEN-1:0] x;
    do_reset();
    out_ready = 1'b1;
    x = rand_act();
    b = rand_phv();
    action_in = x; action_in_valid = 1'b1;
    step();
    idle_inputs();
    for (int i = 0; i < 14; i++) step();
    tests_run++;
    if (err_orphan !== 1'b0 || action_in_ready !== 1'b0) begin tests_failed++; $display("FAIL orphan_early: got err %0b ready %0b expected 0 0", err_orphan, action_in_ready); end
    for (int i = 0; i < 6; i++) step();
    tests_run++;
    if (err_orphan !== 1'b1 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL orphan_set: got err %0b valid %0b expected 1 0", err_orphan, out_valid); end
    phv_in = b; phv_in_valid = 1'b1;
    step();
    idle_inputs();
    step();
    tests_run++;
    if (out_valid !== 1'b1 || phv_out !== b || action_out !== x) begin
      tests_failed++;
      $display("FAIL orphan_pair: got valid %0b phv %0h act %0h expected 1 %0h %0h", out_valid, phv_out[63:0], action_out[63:0], b[63:0], x[63:0]);
    end
    step();
    tests_run++;
    if (err_orphan !== 1'b1 || action_in_ready !== 1'b1) begin tests_failed++; $display("FAIL orphan_sticky: got err %0b ready %0b expected 1 1", err_orphan, action_in_ready); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    phv_in = rand_phv(); phv_in_valid = 1'b1;
    action_in = rand_act(); action_in_valid = 1'b1;
    step();
    action_in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      phv_in = rand_phv();
      step();
    end
    phv_in_valid = 1'b0;
    tests_run++;
    if (fifo_level !== LVL_W'(3) || out_valid !== 1'b1) begin tests_failed++; $display("FAIL midrst_pre: got level %0d valid %0b expected 3 1", fifo_level, out_valid); end
    rst = 1'b1;
    step();
    tests_run++;
    if (out_valid !== 1'b0 || phv_out !== '0 || action_out !== '0 || fifo_level !== '0 ||
        pair_cnt !== '0 || stall_cnt !== '0 || err_orphan !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_clear: got valid %0b level %0d pair %0d stall %0d expected all 0", out_valid, fifo_level, pair_cnt, stall_cnt);
    end
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    tests_run++;
    if (out_valid !== 1'b0 || fifo_level !== '0 || pair_cnt !== '0) begin
      tests_failed++;
      $display("FAIL midrst_quiet: got valid %0b level %0d pair %0d expected 0 0 0", out_valid, fifo_level, pair_cnt);
    end
  endtask

  task automatic test_random();
    logic [PHV_LEN-1:0] phv_q [$];
    logic [ACT_LEN-1:0] act_q [$];
    logic [PHV_LEN-1:0] cur_phv, exp_phv;
    logic [ACT_LEN-1:0] cur_act, exp_act;
    int phv_acc, act_acc, got, stall_model, cycles;
    do_reset();
    phv_acc = 0; act_acc = 0; got = 0; stall_model = 0; cycles = 0;
    cur_phv = rand_phv();
    cur_act = rand_act();
    while (got < int'(N_RAND) && cycles < int'(CYC_LIM)) begin
      phv_in          = cur_phv;
      phv_in_valid    = (phv_acc < int'(N_RAND)) && ($urandom_range(0, 99) < 70);
      action_in       = cur_act;
      action_in_valid = (act_acc < phv_acc) && ($urandom_range(0, 99) < 60);
      out_ready       = ($urandom_range(0, 99) < 70);
      @(negedge clk);
      if (out_valid && !out_ready) stall_model++;
      if (out_valid && out_ready) begin
        tests_run++;
        if (phv_q.size() == 0 || act_q.size() == 0) begin
          tests_failed++;
          $display("FAIL rand_spurious: got issue #%0d with %0d phv %0d act queued expected none", got, phv_q.size(), act_q.size());
        end else begin
          exp_phv = phv_q.pop_front();
          exp_act = act_q.pop_front();
          if (phv_out !== exp_phv || action_out !== exp_act) begin
            tests_failed++;
            $display("FAIL rand_pair%0d: got phv %0h act %0h expected %0h %0h", got, phv_out[63:0], action_out[63:0], exp_phv[63:0], exp_act[63:0]);
          end
        end
        got++;
      end
      if (phv_in_valid && phv_in_ready) begin
        phv_q.push_back(cur_phv);
        phv_acc++;
        cur_phv = rand_phv();
      end
      if (action_in_valid && action_in_ready) begin
        act_q.push_back(cur_act);
        act_acc++;
        cur_act = rand_act();
      end
      step();
      cycles++;
    end
    idle_inputs();
    tests_run++;
    if (got != int'(N_RAND)) begin tests_failed++; $display("FAIL rand_timeout: got %0d pairs in %0d cycles expected %0d", got, cycles, N_RAND); end
    tests_run++;
    if (pair_cnt !== CNT_W'(N_RAND)) begin tests_failed++; $display("FAIL rand_pair_cnt: got %0d expected %0d", pair_cnt, N_RAND); end
    tests_run++;
    if (stall_cnt !== CNT_W'(stall_model)) begin tests_failed++; $display("FAIL rand_stall_cnt: got %0d expected %0d", stall_cnt, stall_model); end
    tests_run++;
    if (err_orphan !== 1'b0 || fifo_level !== '0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rand_end_state: got err %0b level %0d valid %0b expected 0 0 0", err_orphan, fifo_level, out_valid);
    end
  endtask

  initial begin
    rst = 1'b1;
    phv_in = '0; phv_in_valid = 1'b0;
    action_in = '0; action_in_valid = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_single_pair();
    test_fill_then_drain();
    test_stall();
    test_orphan();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
